// File: rtl/maxpool_pkg.sv
// Shared types and reference helpers for the 1D max-pool stage.
package maxpool_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef struct packed {
        logic                          sign;
        logic [DEFAULT_DATA_WIDTH-2:0] mag;
    } sm_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic sm_t relu(input sm_t x);
        return x.sign ? '0 : x;
    endfunction

    // Operands are already clamped, so only magnitudes matter; ties favour b.
    function automatic sm_t smax(input sm_t a, input sm_t b);
        return (a.mag > b.mag) ? a : b;
    endfunction

endpackage

// File: rtl/sm_relu_max.sv
// Combinational ReLU clamp plus sign-magnitude max of two operands (ties return b).
module sm_relu_max
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] reluB,
    output logic [DATA_WIDTH-1:0] maxOut
);

    logic [DATA_WIDTH-1:0] reluA;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        reluA  = a[DATA_WIDTH-1] ? '0 : a;
        reluB  = b[DATA_WIDTH-1] ? '0 : b;
        maxOut = (reluA[DATA_WIDTH-2:0] > reluB[DATA_WIDTH-2:0]) ? reluA : reluB;
    end

endmodule

// File: rtl/maxpool1d_stream.sv
// Streaming 1D max-pool with ReLU over channel-interleaved sign-magnitude samples.
// Define MAXPOOL_CEIL_EN for ceil mode: partial tail windows are flushed instead of dropped.
module maxpool1d_stream
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CHANNELS   = 8,
    parameter int POOL_SIZE  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  tail_drop,
    output logic                  err
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WW = $clog2(POOL_SIZE);
    localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(POOL_SIZE - 1);

    state_t                state, stateNext;
    logic [CW-1:0]         chCnt;
    logic [WW-1:0]         winCnt;
    logic [DATA_WIDTH-1:0] bufMem [CHANNELS];
    logic [DATA_WIDTH-1:0] reluIn, maxIn, loadData;
    logic                  accept, chEnd, winEnd, errStep, tailStep, bufWrite, runLoad;
    logic                  loadOut, loadLast;

`ifdef MAXPOOL_CEIL_EN
    localparam int FW = $clog2(CHANNELS + 1);
    logic [FW-1:0] flushIdx;
    logic          flushLoad;
`endif

    sm_relu_max #(.DATA_WIDTH(DATA_WIDTH)) uRelMax (
        .a      (bufMem[chCnt]),
        .b      (in_data),
        .reluB  (reluIn),
        .maxOut (maxIn)
    );

    assign accept   = in_valid && in_ready;
    assign chEnd    = (chCnt == CH_LAST);
    assign winEnd   = (winCnt == WIN_LAST);
    assign errStep  = accept && in_last && !chEnd;
    assign tailStep = accept && in_last && chEnd && !winEnd;
    assign bufWrite = accept && !winEnd && !errStep;
    assign runLoad  = accept && winEnd && !errStep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
`ifdef MAXPOOL_CEIL_EN
        if (state == RUN && tailStep)
            stateNext = FLUSH;
        else if (state == FLUSH && flushIdx == FW'(CHANNELS) && out_ready)
            stateNext = RUN;
`endif
    end

    always_comb begin
        in_ready = (state == RUN) && (!out_valid || out_ready);
`ifdef MAXPOOL_CEIL_EN
        flushLoad = (state == FLUSH) && (flushIdx != FW'(CHANNELS)) && (!out_valid || out_ready);
`endif
    end

    always_comb begin
        loadOut  = runLoad;
        loadData = maxIn;
        loadLast = in_last;
`ifdef MAXPOOL_CEIL_EN
        if (flushLoad) begin
            loadOut  = 1'b1;
            loadData = bufMem[flushIdx[CW-1:0]];
            loadLast = (flushIdx == FW'(CHANNELS - 1));
        end
`endif
    end

    // NOTE: the window buffer carries no reset; every entry is rewritten at win_cnt 0 before it is read.
    always_ff @(posedge clk) begin
        if (bufWrite)
            bufMem[chCnt] <= (winCnt == '0) ? reluIn : maxIn;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chCnt     <= '0;
            winCnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            tail_drop <= 1'b0;
            err       <= 1'b0;
        end else begin
`ifdef MAXPOOL_CEIL_EN
            tail_drop <= 1'b0;
`else
            tail_drop <= tailStep;
`endif
            if (errStep)
                err <= 1'b1;

            if (loadOut) begin
                out_valid <= 1'b1;
                out_data  <= loadData;
                out_last  <= loadLast;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Any in_last ends the frame; a clean boundary would wrap both counters to zero anyway.
            if (accept) begin
                if (in_last) begin
                    chCnt  <= '0;
                    winCnt <= '0;
                end else if (chEnd) begin
                    chCnt  <= '0;
                    winCnt <= winEnd ? '0 : winCnt + 1'b1;
                end else begin
                    chCnt <= chCnt + 1'b1;
                end
            end
        end
    end

`ifdef MAXPOOL_CEIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flushIdx <= '0;
        else if (state == RUN)
            flushIdx <= '0;
        else if (flushLoad)
            flushIdx <= flushIdx + 1'b1;
    end
`endif

endmodule
